// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: counts upstream timer ticks to a programmable match value
// and raises sticky irq/overflow flags. Optional: TIMER_IRQ_MISS_CNT_EN.
module timer_irq_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic                 mode_i,
    input  logic [CNT_WIDTH-1:0] match_i,
    input  logic                 irq_clr_i,
    output logic                 irq_o,
    output logic                 ovf_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] tick_cnt_o
`ifdef TIMER_IRQ_MISS_CNT_EN
    ,
    output logic [7:0]           miss_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   match_r;
    logic                   mode_r;
    logic [CNT_WIDTH-1:0]   match_m1;
    logic                   match_ev;
    logic                   ovf_set;

    assign match_m1 = match_r - CNT_WIDTH'(1);

    // A counted tick on the last count of the period is a match event;
    // ticks coinciding with start/stop are dropped.
    always_comb begin
        match_ev = 1'b0;
        if (state == RUN && tick_i && !stop_i && !start_i)
            match_ev = (tick_cnt_o == match_m1);
        ovf_set = match_ev && irq_o && !irq_clr_i;
    end

    // Control FSM, tick counter and sticky interrupt flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            tick_cnt_o <= '0;
            match_r    <= '0;
            mode_r     <= 1'b0;
            irq_o      <= 1'b0;
            ovf_o      <= 1'b0;
        end else begin
            if (match_ev)
                irq_o <= 1'b1;
            else if (irq_clr_i)
                irq_o <= 1'b0;

            if (ovf_set)
                ovf_o <= 1'b1;
            else if (irq_clr_i)
                ovf_o <= 1'b0;

            if (stop_i) begin
                state      <= IDLE;
                busy_o     <= 1'b0;
                tick_cnt_o <= '0;
            end else if (start_i) begin
                state      <= RUN;
                busy_o     <= 1'b1;
                tick_cnt_o <= '0;
                match_r    <= (match_i == '0) ? CNT_WIDTH'(1) : match_i;
                mode_r     <= mode_i;
            end else begin
                unique case (state)
                    RUN: begin
                        if (match_ev) begin
                            if (mode_r) begin
                                tick_cnt_o <= '0;
                            end else begin
                                state      <= DONE;
                                busy_o     <= 1'b0;
                                tick_cnt_o <= match_r;
                            end
                        end else if (tick_i) begin
                            tick_cnt_o <= tick_cnt_o + CNT_WIDTH'(1);
                        end
                    end
                    IDLE, DONE: begin
                    end
                    default: begin
                        state      <= IDLE;
                        busy_o     <= 1'b0;
                        tick_cnt_o <= '0;
                    end
                endcase
            end
        end
    end

`ifdef TIMER_IRQ_MISS_CNT_EN
    // Saturating count of matches that landed on a still-pending irq.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            miss_cnt_o <= '0;
        else if (irq_clr_i)
            miss_cnt_o <= '0;
        else if (ovf_set && miss_cnt_o != 8'hFF)
            miss_cnt_o <= miss_cnt_o + 8'd1;
    end
`endif

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: scenario tasks drive timer_irq_ctrl and check
// queued expectations against its outputs one cycle later.
module tb_timer_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        tick_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [15:0] match_i = '0;
    logic        irq_clr_i = 1'b0;
    logic        irq_o;
    logic        ovf_o;
    logic        busy_o;
    logic [15:0] tick_cnt_o;
`ifdef TIMER_IRQ_MISS_CNT_EN
    logic [7:0]  miss_cnt_o;
`endif

    timer_irq_ctrl #(.CNT_WIDTH(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tick_i     (tick_i),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .mode_i     (mode_i),
        .match_i    (match_i),
        .irq_clr_i  (irq_clr_i),
        .irq_o      (irq_o),
        .ovf_o      (ovf_o),
        .busy_o     (busy_o),
        .tick_cnt_o (tick_cnt_o)
`ifdef TIMER_IRQ_MISS_CNT_EN
        ,
        .miss_cnt_o (miss_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        tick;
        logic        start;
        logic        stop;
        logic        clr;
        logic        mode;
        logic [15:0] match;
        logic        irq;
        logic        ovf;
        logic        busy;
        logic [15:0] cnt;
    } step_t;

    typedef struct {
        logic        irq;
        logic        ovf;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Drive one cycle of stimulus and queue what the DUT must show after it.
    task automatic apply(input step_t s);
        exp_t e;
        rst_i     = s.rst;
        tick_i    = s.tick;
        start_i   = s.start;
        stop_i    = s.stop;
        irq_clr_i = s.clr;
        mode_i    = s.mode;
        match_i   = s.match;
        e.irq  = s.irq;
        e.ovf  = s.ovf;
        e.busy = s.busy;
        e.cnt  = s.cnt;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        exp_t  e;
        step_t t [4] = '{
            '{1,1,0,0,0,0,16'd0, 0,0,0,16'd0},
            '{1,0,0,0,0,0,16'd0, 0,0,0,16'd0},
            '{0,1,0,0,0,0,16'd0, 0,0,0,16'd0},
            '{0,1,0,0,0,0,16'd0, 0,0,0,16'd0}
        };
        for (int i = 0; i < 4; i++) begin
            apply(t[i]);
            e = sb.pop_front();
            n_vec++;
            if (irq_o !== e.irq || ovf_o !== e.ovf ||
                busy_o !== e.busy || tick_cnt_o !== e.cnt) begin
                n_err++;
                $display("FAIL reset[%0d]: got irq=%b ovf=%b busy=%b cnt=%0d want irq=%b ovf=%b busy=%b cnt=%0d",
                         i, irq_o, ovf_o, busy_o, tick_cnt_o,
                         e.irq, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_periodic();
        exp_t  e;
        step_t t [8] = '{
            '{0,0,1,0,0,1,16'd3, 0,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 0,0,1,16'd1},
            '{0,1,0,0,0,0,16'd0, 0,0,1,16'd2},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd1},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd2},
            '{0,1,0,0,0,0,16'd0, 1,1,1,16'd0},
            '{0,0,0,0,1,0,16'd0, 0,0,1,16'd0}
        };
        for (int i = 0; i < 8; i++) begin
            apply(t[i]);
            e = sb.pop_front();
            n_vec++;
            if (irq_o !== e.irq || ovf_o !== e.ovf ||
                busy_o !== e.busy || tick_cnt_o !== e.cnt) begin
                n_err++;
                $display("FAIL periodic[%0d]: got irq=%b ovf=%b busy=%b cnt=%0d want irq=%b ovf=%b busy=%b cnt=%0d",
                         i, irq_o, ovf_o, busy_o, tick_cnt_o,
                         e.irq, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_oneshot();
        exp_t  e;
        step_t t [6] = '{
            '{0,0,1,0,0,0,16'd2, 0,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 0,0,1,16'd1},
            '{0,1,0,0,0,0,16'd0, 1,0,0,16'd2},
            '{0,1,0,0,0,0,16'd0, 1,0,0,16'd2},
            '{0,1,0,0,0,0,16'd0, 1,0,0,16'd2},
            '{0,0,0,0,1,0,16'd0, 0,0,0,16'd2}
        };
        for (int i = 0; i < 6; i++) begin
            apply(t[i]);
            e = sb.pop_front();
            n_vec++;
            if (irq_o !== e.irq || ovf_o !== e.ovf ||
                busy_o !== e.busy || tick_cnt_o !== e.cnt) begin
                n_err++;
                $display("FAIL oneshot[%0d]: got irq=%b ovf=%b busy=%b cnt=%0d want irq=%b ovf=%b busy=%b cnt=%0d",
                         i, irq_o, ovf_o, busy_o, tick_cnt_o,
                         e.irq, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_clr_race();
        exp_t  e;
        step_t t [9] = '{
            '{0,0,1,0,0,1,16'd2, 0,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 0,0,1,16'd1},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd1},
            '{0,1,0,0,1,0,16'd0, 1,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd1},
            '{0,0,0,0,1,0,16'd0, 0,0,1,16'd1},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd0},
            '{0,0,0,0,1,0,16'd0, 0,0,1,16'd0}
        };
        for (int i = 0; i < 9; i++) begin
            apply(t[i]);
            e = sb.pop_front();
            n_vec++;
            if (irq_o !== e.irq || ovf_o !== e.ovf ||
                busy_o !== e.busy || tick_cnt_o !== e.cnt) begin
                n_err++;
                $display("FAIL clr_race[%0d]: got irq=%b ovf=%b busy=%b cnt=%0d want irq=%b ovf=%b busy=%b cnt=%0d",
                         i, irq_o, ovf_o, busy_o, tick_cnt_o,
                         e.irq, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_match_zero();
        exp_t  e;
        step_t t [6] = '{
            '{0,0,1,0,0,1,16'd0, 0,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,1,1,16'd0},
            '{0,0,0,0,1,0,16'd0, 0,0,1,16'd0},
            '{0,1,1,0,0,0,16'd5, 0,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 0,0,1,16'd1}
        };
        for (int i = 0; i < 6; i++) begin
            apply(t[i]);
            e = sb.pop_front();
            n_vec++;
            if (irq_o !== e.irq || ovf_o !== e.ovf ||
                busy_o !== e.busy || tick_cnt_o !== e.cnt) begin
                n_err++;
                $display("FAIL match_zero[%0d]: got irq=%b ovf=%b busy=%b cnt=%0d want irq=%b ovf=%b busy=%b cnt=%0d",
                         i, irq_o, ovf_o, busy_o, tick_cnt_o,
                         e.irq, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_stop_reset();
        exp_t  e;
        step_t t [17] = '{
            '{0,0,1,0,0,0,16'd0, 0,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,0,0,16'd1},
            '{0,1,0,0,0,0,16'd0, 1,0,0,16'd1},
            '{0,0,1,0,0,0,16'd5, 1,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd1},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd2},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd3},
            '{0,1,0,1,0,0,16'd0, 1,0,0,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,0,0,16'd0},
            '{0,0,1,0,0,0,16'd5, 1,0,1,16'd0},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd1},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd2},
            '{0,1,0,0,0,0,16'd0, 1,0,1,16'd3},
            '{1,1,0,0,0,0,16'd0, 0,0,0,16'd0},
            '{0,1,0,0,0,0,16'd0, 0,0,0,16'd0},
            '{0,0,1,1,0,1,16'd4, 0,0,0,16'd0},
            '{0,1,0,0,0,0,16'd0, 0,0,0,16'd0}
        };
        for (int i = 0; i < 17; i++) begin
            apply(t[i]);
            e = sb.pop_front();
            n_vec++;
            if (irq_o !== e.irq || ovf_o !== e.ovf ||
                busy_o !== e.busy || tick_cnt_o !== e.cnt) begin
                n_err++;
                $display("FAIL stop_reset[%0d]: got irq=%b ovf=%b busy=%b cnt=%0d want irq=%b ovf=%b busy=%b cnt=%0d",
                         i, irq_o, ovf_o, busy_o, tick_cnt_o,
                         e.irq, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk_i);
        #1;
        test_reset();
        test_periodic();
        test_oneshot();
        test_clr_race();
        test_match_zero();
        test_stop_reset();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: got %0d leftover want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
